accumulator_stage: RTL and testbench

Sequential accumulator that consumes the sum and carry-out of a WIDTH-bit ripple-carry adder. It sums a burst of WIDTH-bit operands delivered over a valid/ready stream, with the end of a burst marked by `in_last`. It then presents the total, a sticky overflow flag and a beat count on a valid/ready output stream. It sits directly downstream of the adder: the adder's `a` input is fed from the accumulator register and its `b` input from the incoming operand.

---
 rtl/accumulator_stage_pkg.sv | 7 +
 rtl/accumulator_stage_adder.sv | 22 ++
 rtl/accumulator_stage.sv | 115 +++++++++++
 tb/tb_accumulator_stage.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/accumulator_stage_pkg.sv
// Shared definitions for the accumulator stage: FSM state encodings.
package accumulator_stage_pkg;

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

endpackage

// File: rtl/accumulator_stage_adder.sv
// WIDTH-bit ripple-carry adder that feeds the accumulator register.
module ripple_carry_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    logic [WIDTH:0] carry;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign sum[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1]   = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign carry_out = carry[WIDTH];

endmodule

// File: rtl/accumulator_stage.sv
// Burst accumulator: sums operands until in_last, then holds the total,
// sticky overflow and beat count until the consumer takes them.
//   state    | meaning
//   ST_ACCUM | accepting beats, in_ready = 1
//   ST_HOLD  | result presented, waiting for out_ready
module accumulator_stage
    import accumulator_stage_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int COUNT_WIDTH = 4,
    parameter int SATURATE    = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_sum,
    output logic                   out_overflow,
    output logic [COUNT_WIDTH-1:0] out_count
);

    logic [0:0]             state_q, state_d;
    logic [WIDTH-1:0]       acc_q, acc_d;
    logic                   ovf_q, ovf_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]       out_sum_q, out_sum_d;
    logic                   out_ovf_q, out_ovf_d;
    logic [COUNT_WIDTH-1:0] out_cnt_q, out_cnt_d;

    logic [WIDTH-1:0]       add_sum;
    logic                   add_carry;
    logic [WIDTH-1:0]       acc_upd;
    logic                   ovf_upd;
    logic [COUNT_WIDTH-1:0] cnt_upd;
    logic                   beat;

    ripple_carry_adder #(.WIDTH(WIDTH)) u_adder (
        .a         (acc_q),
        .b         (in_data),
        .sum       (add_sum),
        .carry_out (add_carry)
    );

    // in_ready is decoded from the state register only, never from out_ready.
    assign in_ready     = (state_q == ST_ACCUM);
    assign out_valid    = (state_q == ST_HOLD);
    assign out_sum      = out_sum_q;
    assign out_overflow = out_ovf_q;
    assign out_count    = out_cnt_q;
    assign beat         = in_valid && in_ready;

    always_comb begin
        acc_upd = (add_carry && (SATURATE != 0)) ? '1 : add_sum;
        ovf_upd = ovf_q | add_carry;
        cnt_upd = (&cnt_q) ? cnt_q : cnt_q + COUNT_WIDTH'(1);

        state_d   = state_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        cnt_d     = cnt_q;
        out_sum_d = out_sum_q;
        out_ovf_d = out_ovf_q;
        out_cnt_d = out_cnt_q;

        case (state_q)
            ST_ACCUM: begin
                if (beat) begin
                    if (in_last) begin
                        state_d   = ST_HOLD;
                        out_sum_d = acc_upd;
                        out_ovf_d = ovf_upd;
                        out_cnt_d = cnt_upd;
                        acc_d     = '0;
                        ovf_d     = 1'b0;
                        cnt_d     = '0;
                    end else begin
                        acc_d = acc_upd;
                        ovf_d = ovf_upd;
                        cnt_d = cnt_upd;
                    end
                end
            end
            default: begin
                if (out_ready) begin
                    state_d = ST_ACCUM;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_ACCUM;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
            out_sum_q <= '0;
            out_ovf_q <= 1'b0;
            out_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            cnt_q     <= cnt_d;
            out_sum_q <= out_sum_d;
            out_ovf_q <= out_ovf_d;
            out_cnt_q <= out_cnt_d;
        end
    end

endmodule

// File: tb/tb_accumulator_stage.sv
// Bench for accumulator_stage: wrap and saturate instances share one stimulus stream.
module tb_accumulator_stage;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b0;

    logic       w_in_ready, w_out_valid, w_out_ovf;
    logic [7:0] w_out_sum;
    logic [3:0] w_out_cnt;
    logic       s_in_ready, s_out_valid, s_out_ovf;
    logic [7:0] s_out_sum;
    logic [3:0] s_out_cnt;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    accumulator_stage #(.WIDTH(8), .COUNT_WIDTH(4), .SATURATE(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(w_out_valid),
        .out_ready(out_ready), .out_sum(w_out_sum), .out_overflow(w_out_ovf),
        .out_count(w_out_cnt)
    );

    accumulator_stage #(.WIDTH(8), .COUNT_WIDTH(4), .SATURATE(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(s_out_valid),
        .out_ready(out_ready), .out_sum(s_out_sum), .out_overflow(s_out_ovf),
        .out_count(s_out_cnt)
    );

    typedef struct {
        string      name;
        int         nbeats;
        logic [7:0] d0, d1, d2;   // beats 2.. repeat d2
        logic [7:0] exp_wrap;
        logic [7:0] exp_sat;
        logic       exp_ovf;
        logic [3:0] exp_cnt;
    } vec_t;

    vec_t vecs[8];
    logic [7:0] beat_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: a burst's result depends only on the plain sum of its beats and their number.
    task automatic model(input int sum_all, input int n,
                         output logic [7:0] ew, output logic [7:0] es,
                         output logic eo, output logic [3:0] ec);
        ew = 8'(sum_all % 256);
        es = (sum_all > 255) ? 8'hFF : 8'(sum_all);
        eo = (sum_all > 255);
        ec = (n > 15) ? 4'hF : 4'(n);
    endtask

    task automatic check_hold(input string name, input logic [7:0] ew, input logic [7:0] es,
                              input logic eo, input logic [3:0] ec);
        check({name, " w_valid"}, 32'(w_out_valid), 32'd1);
        check({name, " s_valid"}, 32'(s_out_valid), 32'd1);
        check({name, " w_in_ready"}, 32'(w_in_ready), 32'd0);
        check({name, " s_in_ready"}, 32'(s_in_ready), 32'd0);
        check({name, " w_sum"}, 32'(w_out_sum), 32'(ew));
        check({name, " s_sum"}, 32'(s_out_sum), 32'(es));
        check({name, " w_ovf"}, 32'(w_out_ovf), 32'(eo));
        check({name, " s_ovf"}, 32'(s_out_ovf), 32'(eo));
        check({name, " w_cnt"}, 32'(w_out_cnt), 32'(ec));
        check({name, " s_cnt"}, 32'(s_out_cnt), 32'(ec));
    endtask

    // Sends beat_q as one burst; outputs are checked on the cycle after the last beat.
    task automatic send_burst(input string name, input logic [7:0] ew, input logic [7:0] es,
                              input logic eo, input logic [3:0] ec, input bit random_gaps);
        int n = beat_q.size();
        for (int i = 0; i < n; i++) begin
            if (random_gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    in_valid  = 1'b0;
                    in_data   = 8'($urandom);
                    in_last   = 1'($urandom);
                    out_ready = 1'($urandom);
                    step();
                end
                out_ready = 1'($urandom);
            end
            in_valid = 1'b1;
            in_data  = beat_q[i];
            in_last  = (i == n - 1);
            if (!w_in_ready || !s_in_ready)
                check({name, " in_ready while accumulating"}, 32'({w_in_ready, s_in_ready}), 32'd3);
            step();
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        check_hold(name, ew, es, eo, ec);
    endtask

    task automatic release_output(input string name);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({name, " w_valid drop"}, 32'(w_out_valid), 32'd0);
        check({name, " w_in_ready back"}, 32'(w_in_ready), 32'd1);
        check({name, " s_in_ready back"}, 32'(s_in_ready), 32'd1);
    endtask

    initial begin
        vecs[0] = '{"basic",     3, 8'h10, 8'h20, 8'h05, 8'h35, 8'h35, 1'b0, 4'd3};
        vecs[1] = '{"wrap_ovf",  2, 8'hF0, 8'h20, 8'h20, 8'h10, 8'hFF, 1'b1, 4'd2};
        vecs[2] = '{"after_ovf", 1, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 1'b0, 4'd1};
        vecs[3] = '{"sat3",      3, 8'hF0, 8'h20, 8'h01, 8'h11, 8'hFF, 1'b1, 4'd3};
        vecs[4] = '{"cnt_sat",  20, 8'h01, 8'h01, 8'h01, 8'h14, 8'h14, 1'b0, 4'hF};
        vecs[5] = '{"exact256",  2, 8'hFF, 8'h01, 8'h01, 8'h00, 8'hFF, 1'b1, 4'd2};
        vecs[6] = '{"ff_zeros",  3, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF, 1'b0, 4'd3};
        vecs[7] = '{"cnt15",    15, 8'h02, 8'h03, 8'h00, 8'h05, 8'h05, 1'b0, 4'hF};

        #12;
        check("reset w_valid", 32'(w_out_valid), 32'd0);
        check("reset w_sum", 32'(w_out_sum), 32'd0);
        check("reset w_cnt", 32'(w_out_cnt), 32'd0);
        check("reset w_in_ready", 32'(w_in_ready), 32'd1);
        rst_n = 1'b1;
        step();

        foreach (vecs[k]) begin
            beat_q.delete();
            for (int i = 0; i < vecs[k].nbeats; i++)
                beat_q.push_back(i == 0 ? vecs[k].d0 : (i == 1 ? vecs[k].d1 : vecs[k].d2));
            send_burst(vecs[k].name, vecs[k].exp_wrap, vecs[k].exp_sat,
                       vecs[k].exp_ovf, vecs[k].exp_cnt, 1'b0);
            release_output(vecs[k].name);
        end

        // Backpressure: output held, input beats ignored while waiting.
        beat_q.delete();
        beat_q.push_back(8'h7A);
        send_burst("bp", 8'h7A, 8'h7A, 1'b0, 4'd1, 1'b0);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_data  = 8'hC3;
            in_last  = 1'($urandom);
            step();
            check_hold("bp_wait", 8'h7A, 8'h7A, 1'b0, 4'd1);
        end
        in_valid = 1'b0;
        release_output("bp");
        beat_q.delete();
        beat_q.push_back(8'h01);
        send_burst("bp_after", 8'h01, 8'h01, 1'b0, 4'd1, 1'b0);
        release_output("bp_after");

        // Reset mid-burst: previous result registers still hold 0x01.
        in_valid = 1'b1; in_data = 8'h33; in_last = 1'b0; step();
        in_data = 8'h44; step();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid w_sum", 32'(w_out_sum), 32'd0);
        check("rst_mid w_cnt", 32'(w_out_cnt), 32'd0);
        check("rst_mid s_in_ready", 32'(s_in_ready), 32'd1);
        @(negedge clk) rst_n = 1'b1;
        step();
        beat_q.delete();
        beat_q.push_back(8'h02);
        send_burst("rst_after", 8'h02, 8'h02, 1'b0, 4'd1, 1'b0);

        // Reset while holding a result.
        #2 rst_n = 1'b0;
        #1;
        check("rst_hold w_valid", 32'(w_out_valid), 32'd0);
        check("rst_hold s_sum", 32'(s_out_sum), 32'd0);
        check("rst_hold s_ovf", 32'(s_out_ovf), 32'd0);
        check("rst_hold w_in_ready", 32'(w_in_ready), 32'd1);
        @(negedge clk) rst_n = 1'b1;
        step();

        // Randomized bursts against the arithmetic model.
        for (int b = 0; b < 60; b++) begin
            int n, sum_all, hold_cycles;
            logic [7:0] ew, es;
            logic eo;
            logic [3:0] ec;
            n = $urandom_range(1, 20);
            sum_all = 0;
            beat_q.delete();
            for (int i = 0; i < n; i++) begin
                logic [7:0] d;
                d = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
                beat_q.push_back(d);
                sum_all += int'(d);
            end
            model(sum_all, n, ew, es, eo, ec);
            send_burst($sformatf("rand%0d", b), ew, es, eo, ec, 1'b1);
            hold_cycles = $urandom_range(0, 3);
            for (int c = 0; c < hold_cycles; c++) begin
                in_valid = 1'($urandom);
                in_data  = 8'($urandom);
                in_last  = 1'($urandom);
                step();
                check_hold($sformatf("rand%0d_hold", b), ew, es, eo, ec);
            end
            in_valid = 1'b0;
            release_output($sformatf("rand%0d", b));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
